// File: rtl/nn_pkg.sv
// nn_pkg: shared constants for the small feed-forward network and its
// backward-direction blocks.
//   - Network geometry (data width, input width, layer sizes)
//   - Output-gradient defaults (update width, learning-rate shift)
//   - FSM state encoding for the output-gradient sequencer
//   - Width helpers for the error/product datapath
package nn_pkg;

    localparam int NN_DW      = 17;
    localparam int NN_XW      = 9;
    localparam int NN_NUM_IN  = 4;
    localparam int NN_NUM_HID = 4;
    localparam int NN_NUM_OUT = 2;

    localparam int NN_GW       = 17;
    localparam int NN_LR_SHIFT = 8;

    // One update per (output neuron, hidden neuron) pair.
    localparam int NN_NUM_UPD = NN_NUM_OUT * NN_NUM_HID;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ERR  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Difference of two dw-bit signed values is exact in dw+1 bits.
    function automatic int nn_err_w(input int dw);
        return dw + 1;
    endfunction

    // Product of an error (dw+1 bits) and an activation (dw bits).
    function automatic int nn_prod_w(input int dw);
        return 2 * dw + 1;
    endfunction

endpackage

// File: rtl/nn_shift_sat.sv
// nn_shift_sat: combinational arithmetic right shift followed by signed
// saturation to a narrower width.
//   din  in  IW  signed value
//   dout out OW  signed, sat_OW(din >>> SH), shift rounds toward -inf
// IW must be >= OW.
module nn_shift_sat #(
    parameter int IW = 35,
    parameter int OW = 17,
    parameter int SH = 8
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout
);

    // Output range limits expressed at the input width so the comparison
    // is done on the full shifted value.
    localparam logic signed [IW-1:0] MAX_V = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] MIN_V = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [IW-1:0] shifted;

    // Arithmetic shift of a signed operand floors toward minus infinity.
    assign shifted = din >>> SH;

    always_comb begin
        dout = shifted[OW-1:0];
        if (shifted > MAX_V) begin
            dout = MAX_V[OW-1:0];
        end else if (shifted < MIN_V) begin
            dout = MIN_V[OW-1:0];
        end
    end

endmodule

// File: rtl/nn_output_grad.sv
// nn_output_grad: output-layer weight-gradient sequencer.
// Captures one inference (y0,y1), its targets (t0,t1) and the hidden
// activations (h0..h3), forms errors e_k = t_k - y_k, then streams the
// eight updates dw[k][j] = sat((e_k * h_j) >>> LR_SHIFT) through one
// shared multiplier over a valid/ready handshake.
//   CLK, RST         clock (rising edge), async active-high reset
//   start            capture request, ignored while busy
//   y0,y1,t0,t1      outputs / targets (DW signed)
//   h0..h3           hidden activations (DW signed)
//   busy             high from start acceptance until DONE exits
//   e0,e1            registered errors (DW+1 signed)
//   dw_valid/ready   update handshake
//   dw_data          update value (GW signed, saturated)
//   dw_k, dw_j       output / hidden neuron index of the update
//   done             one-cycle pulse after the last update is accepted
module nn_output_grad
    import nn_pkg::*;
#(
    parameter int DW       = NN_DW,
    parameter int GW       = NN_GW,
    parameter int LR_SHIFT = NN_LR_SHIFT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic signed [DW-1:0] y0,
    input  logic signed [DW-1:0] y1,
    input  logic signed [DW-1:0] t0,
    input  logic signed [DW-1:0] t1,
    input  logic signed [DW-1:0] h0,
    input  logic signed [DW-1:0] h1,
    input  logic signed [DW-1:0] h2,
    input  logic signed [DW-1:0] h3,
    output logic                 busy,
    output logic signed [DW:0]   e0,
    output logic signed [DW:0]   e1,
    output logic                 dw_valid,
    input  logic                 dw_ready,
    output logic signed [GW-1:0] dw_data,
    output logic                 dw_k,
    output logic [1:0]           dw_j,
    output logic                 done
);

    localparam int EW = nn_err_w(DW);
    localparam int PW = nn_prod_w(DW);
    localparam logic [2:0] LAST_IDX = 3'(NN_NUM_UPD - 1);

    logic [2:0]           state_reg;
    logic [2:0]           idx_reg;
    logic signed [DW-1:0] y0_reg, y1_reg, t0_reg, t1_reg;
    logic signed [DW-1:0] h_reg [NN_NUM_HID];
    logic signed [DW-1:0] h_in  [NN_NUM_HID];

    logic                 accept;
    logic signed [EW-1:0] e_sel;
    logic signed [DW-1:0] h_sel;
    logic signed [PW-1:0] e_ext, h_ext, prod;
    logic signed [GW-1:0] dw_sat;

    assign h_in[0] = h0;
    assign h_in[1] = h1;
    assign h_in[2] = h2;
    assign h_in[3] = h3;

    assign accept = (state_reg == ST_IDLE) && start;

    // Shared multiplier: idx[2] picks the output neuron, idx[1:0] the
    // hidden neuron. Operands are sign-extended to the full product width
    // so the multiply is exact.
    assign e_sel = idx_reg[2] ? e1 : e0;
    assign h_sel = h_reg[idx_reg[1:0]];
    assign e_ext = PW'(e_sel);
    assign h_ext = PW'(h_sel);
    assign prod  = e_ext * h_ext;

    nn_shift_sat #(
        .IW (PW),
        .OW (GW),
        .SH (LR_SHIFT)
    ) u_shift_sat (
        .din  (prod),
        .dout (dw_sat)
    );

    // Operand capture; only an accepted start loads new values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            y0_reg <= '0;
            y1_reg <= '0;
            t0_reg <= '0;
            t1_reg <= '0;
            for (int i = 0; i < NN_NUM_HID; i++) begin
                h_reg[i] <= '0;
            end
        end else if (accept) begin
            y0_reg <= y0;
            y1_reg <= y1;
            t0_reg <= t0;
            t1_reg <= t1;
            for (int i = 0; i < NN_NUM_HID; i++) begin
                h_reg[i] <= h_in[i];
            end
        end
    end

    // Sequencer. Outputs are registered so each state's outputs are
    // visible one edge after it is entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            busy      <= 1'b0;
            e0        <= '0;
            e1        <= '0;
            dw_valid  <= 1'b0;
            dw_data   <= '0;
            dw_k      <= 1'b0;
            dw_j      <= '0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        state_reg <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    e0        <= {t0_reg[DW-1], t0_reg} - {y0_reg[DW-1], y0_reg};
                    e1        <= {t1_reg[DW-1], t1_reg} - {y1_reg[DW-1], y1_reg};
                    idx_reg   <= '0;
                    state_reg <= ST_LOAD;
                end
                ST_LOAD: begin
                    dw_data   <= dw_sat;
                    dw_k      <= idx_reg[2];
                    dw_j      <= idx_reg[1:0];
                    dw_valid  <= 1'b1;
                    state_reg <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (dw_ready) begin
                        dw_valid <= 1'b0;
                        if (idx_reg == LAST_IDX) begin
                            done      <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            idx_reg   <= idx_reg + 3'd1;
                            state_reg <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
